// File: rtl/led_seq_ctrl.sv
// Step sequencer for the LED bar: runs rotate/bounce/fill patterns for a programmed step count.
// Optional LED_SEQ_SPEED_EN adds a `speed` input that divides the step period by 1/2/4/8.
module led_seq_ctrl #(
  parameter int LED_W    = 16,
  parameter int TICK_CNT = 50000000,
  parameter int TW       = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [7:0]       steps,
`ifdef LED_SEQ_SPEED_EN
  input  logic [1:0]       speed,
`endif
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             done,
  output logic             tick
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [LED_W-1:0] MSB_ONE = {1'b1, {(LED_W-1){1'b0}}};
  localparam logic [LED_W-1:0] LSB_ONE = {{(LED_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [TW-1:0]    presc_q, presc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             dir_q, dir_d;      // 0 = shifting right, 1 = shifting left
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       steps_q, steps_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [TW-1:0]    period_m1_s;
  logic             tick_s;
  logic [LED_W-1:0] step_led_s;
  logic             step_dir_s;
  logic [LED_W-1:0] load_led_s;

`ifdef LED_SEQ_SPEED_EN
  logic [1:0] speed_q, speed_d;

  always_comb begin
    period_m1_s = (TW'(TICK_CNT) >> speed_q) - TW'(1);
  end
`else
  always_comb begin
    period_m1_s = TW'(TICK_CNT - 1);
  end
`endif

  assign tick_s = (state_q == ST_RUN) && !pause && (presc_q == period_m1_s);

  // Pattern advance for one tick; bounce flips direction when the lit bit reaches an end.
  always_comb begin
    step_led_s = led_q;
    step_dir_s = dir_q;
    case (mode_q)
      2'b00: step_led_s = {led_q[0], led_q[LED_W-1:1]};
      2'b01: step_led_s = {led_q[LED_W-2:0], led_q[LED_W-1]};
      2'b10: begin
        if (dir_q) begin
          step_led_s = {led_q[LED_W-2:0], 1'b0};
        end else begin
          step_led_s = {1'b0, led_q[LED_W-1:1]};
        end
        if (step_led_s == LSB_ONE) begin
          step_dir_s = 1'b1;
        end else if (step_led_s == MSB_ONE) begin
          step_dir_s = 1'b0;
        end else begin
          step_dir_s = dir_q;
        end
      end
      2'b11: begin
        if (&led_q) begin
          step_led_s = '0;
        end else begin
          step_led_s = {1'b1, led_q[LED_W-1:1]};
        end
      end
      default: step_led_s = led_q;
    endcase
  end

  always_comb begin
    case (mode)
      2'b01:   load_led_s = LSB_ONE;
      2'b11:   load_led_s = '0;
      default: load_led_s = MSB_ONE;
    endcase
  end

  // Next-state logic; stop outranks start in IDLE and outranks a tick in RUN.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    steps_d = steps_q;
`ifdef LED_SEQ_SPEED_EN
    speed_d = speed_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          mode_d  = mode;
          steps_d = steps;
          led_d   = load_led_s;
          presc_d = '0;
          cnt_d   = 8'd0;
          dir_d   = 1'b0;
`ifdef LED_SEQ_SPEED_EN
          speed_d = speed;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick_s) begin
          presc_d = '0;
          cnt_d   = cnt_q + 8'd1;
          led_d   = step_led_s;
          dir_d   = step_dir_s;
          if ((steps_q != 8'd0) && (cnt_d == steps_q)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else if (!pause) begin
          presc_d = presc_q + TW'(1);
        end else begin
          presc_d = presc_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      led_q   <= MSB_ONE;
      presc_q <= '0;
      cnt_q   <= 8'd0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      steps_q <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LED_SEQ_SPEED_EN
      speed_q <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      steps_q <= steps_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LED_SEQ_SPEED_EN
      speed_q <= speed_d;
`endif
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;
  assign tick = tick_s;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed table, hand sequences and random traffic vs a step-indexed model.
module tb_led_seq_ctrl;
  localparam int TCK = 4;

  logic        clk = 1'b0;
  logic        rst, start, stop, pause;
  logic [1:0]  mode;
  logic [7:0]  steps;
  logic [15:0] led;
  logic        busy, done, tick;
`ifdef LED_SEQ_SPEED_EN
  logic [1:0]  speed = 2'b00;
`endif

  led_seq_ctrl #(.LED_W(16), .TICK_CNT(TCK), .TW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .steps(steps),
`ifdef LED_SEQ_SPEED_EN
    .speed(speed),
`endif
    .led(led), .busy(busy), .done(done), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: run state (0 idle, 1 run, 2 done), steps taken n, cycles since last step ph.
  int          m_st = 0;
  int          m_n = 0;
  int          m_ph = 0;
  int          m_steps = 0;
  logic [1:0]  m_mode = 2'b00;
  logic [15:0] m_led = 16'h8000;

  // LED image after n steps of a pattern, from the lit position / fill depth.
  function automatic logic [15:0] pat(input logic [1:0] md, input int n);
    logic [15:0] ones;
    int idx, pos, k;
    ones = 16'hFFFF;
    case (md)
      2'b00: pat = 16'h0001 << (15 - (n % 16));
      2'b01: pat = 16'h0001 << (n % 16);
      2'b10: begin
        idx = n % 30;
        pos = (idx <= 15) ? (15 - idx) : (idx - 15);
        pat = 16'h0001 << pos;
      end
      default: begin
        k = n % 17;
        pat = (k == 0) ? 16'h0000 : (ones << (16 - k));
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_step();
    if (rst) begin
      m_st = 0; m_led = 16'h8000; m_n = 0; m_ph = 0;
    end else begin
      case (m_st)
        0: if (start && !stop) begin
          m_st = 1; m_mode = mode; m_steps = int'(steps);
          m_n = 0; m_ph = 0; m_led = pat(mode, 0);
        end
        1: if (stop) begin
          m_st = 0;
        end else if (!pause) begin
          m_ph++;
          if (m_ph == TCK) begin
            m_ph = 0;
            m_n++;
            m_led = pat(m_mode, m_n);
            if (m_steps != 0 && m_n == m_steps) m_st = 2;
          end
        end
        default: m_st = 0;
      endcase
    end
  endtask

  // One clock: advance model on the edge, then compare all outputs 2 time units later.
  task automatic cycle();
    @(posedge clk);
    m_step();
    #2;
    chk("led", led, m_led);
    chk("busy", {15'd0, busy}, {15'd0, (m_st == 1)});
    chk("done", {15'd0, done}, {15'd0, (m_st == 2)});
    chk("tick", {15'd0, tick}, {15'd0, (m_st == 1 && !pause && m_ph == TCK - 1)});
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  md;
    logic [7:0]  sp;
    int          w;
    logic [15:0] e_led;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 8'd3,  0,  16'h8000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 8'd0,  4,  16'h4000, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 8'd0,  4,  16'h2000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 8'd0,  4,  16'h1000, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 8'd0,  1,  16'h1000, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'd3, 8'd17, 0,  16'h0000, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 8'd0,  4,  16'h8000, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 8'd0,  4,  16'hC000, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 8'd0,  56, 16'hFFFF, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 8'd0,  4,  16'h0000, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 8'd0,  1,  16'h0000, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'd2, 8'd20, 0,  16'h8000, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 8'd0,  60, 16'h0001, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 8'd0,  4,  16'h0002, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 8'd0,  16, 16'h0020, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 2'd0, 8'd0,  1,  16'h0020, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 2'b00; steps = 8'd0;
    repeat (2) cycle();
    chk("rst_led", led, 16'h8000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    rst = 1'b0;
    cycle();

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].st) begin
        start = 1'b1; mode = tbl[i].md; steps = tbl[i].sp;
        cycle();
        start = 1'b0;
      end
      repeat (tbl[i].w) cycle();
      chk($sformatf("tbl%0d_led", i), led, tbl[i].e_led);
      chk($sformatf("tbl%0d_busy", i), {15'd0, busy}, {15'd0, tbl[i].e_busy});
      chk($sformatf("tbl%0d_done", i), {15'd0, done}, {15'd0, tbl[i].e_done});
    end

    // Pause freezes stepping; stop on a tick cycle keeps led and gives no done.
    start = 1'b1; mode = 2'b01; steps = 8'd0;
    cycle();
    start = 1'b0;
    repeat (8) cycle();
    chk("p_led0", led, 16'h0004);
    pause = 1'b1;
    repeat (10) cycle();
    chk("p_led1", led, 16'h0004);
    pause = 1'b0;
    repeat (3) cycle();
    chk("p_tick", {15'd0, tick}, 16'd1);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("stop_led", led, 16'h0004);
    chk("stop_busy", {15'd0, busy}, 16'd0);
    repeat (3) cycle();
    chk("stop_done", {15'd0, done}, 16'd0);

    // start while busy ignored, then reset mid-run.
    start = 1'b1; mode = 2'b00; steps = 8'd0;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    chk("ign_led0", led, 16'h4000);
    start = 1'b1; mode = 2'b01;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    chk("ign_led1", led, 16'h2000);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_led", led, 16'h8000);
    chk("mid_rst_busy", {15'd0, busy}, 16'd0);

    // start and stop together in IDLE: ignored.
    start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", {15'd0, busy}, 16'd0);
    cycle();

    // Random traffic against the model.
    repeat (3000) begin
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 7) == 0);
      mode  = 2'($urandom_range(0, 3));
      steps = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      cycle();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
